mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw).

---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and data (DM) requests.
// Define MEM_ARB_PERF_EN to add the stall_cnt performance counter output.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT = 2,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ARB_PERF_EN
   output logic [31:0]       stall_cnt,
`endif
   output logic              nostall
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e     state_q;
   logic [3:0] cnt_q;
   logic       gnt_dm_q;
   logic       if_done_q;
   logic       dm_done_q;

   // The ready pulse counts as completion so the last port's ready cycle already advances.
   assign nostall = ~((if_req & ~(if_done_q | if_ready)) | (dm_req & ~(dm_done_q | dm_ready)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         gnt_dm_q  <= 1'b0;
         if_done_q <= 1'b0;
         dm_done_q <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_ready  <= 1'b0;
         dm_ready  <= 1'b0;
      end else begin
         mem_en <= 1'b0;
         case (state_q)
            StIdle: begin
               // DM wins: the MEM-stage instruction is older than the fetch.
               if (dm_req && !dm_done_q) begin
                  gnt_dm_q  <= 1'b1;
                  mem_en    <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  cnt_q     <= 4'(MEM_LAT);
                  state_q   <= StAccess;
               end else if (if_req && !if_done_q) begin
                  gnt_dm_q <= 1'b0;
                  mem_en   <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= if_addr;
                  cnt_q    <= 4'(MEM_LAT);
                  state_q  <= StAccess;
               end
            end
            StAccess: begin
               if (cnt_q == 4'd0) begin
                  if (gnt_dm_q) begin
                     if (!mem_we) begin
                        dm_rdata <= mem_rdata;
                     end
                     dm_ready <= 1'b1;
                  end else begin
                     if_rdata <= mem_rdata;
                     if_ready <= 1'b1;
                  end
                  state_q <= StResp;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StResp: begin
               if_ready <= 1'b0;
               dm_ready <= 1'b0;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase

         // A pipeline advance retires both ports, including one completing this cycle.
         if (nostall) begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
         end else begin
            if (if_ready) if_done_q <= 1'b1;
            if (dm_ready) dm_done_q <= 1'b1;
         end
      end
   end

`ifdef MEM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= 32'd0;
      end else if (!nostall) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory model plus per-port read-data scoreboard.
// Build with MEM_ARB_PERF_EN defined to also check stall_cnt.
module tb_mem_port_arbiter;

   localparam int unsigned MemLat = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        nostall;
`ifdef MEM_ARB_PERF_EN
   logic [31:0] stall_cnt;
`endif

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .MEM_LAT(MemLat),
      .ADDR_W (32),
      .DATA_W (32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_ready (if_ready),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_rdata (dm_rdata),
      .dm_ready (dm_ready),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
`ifdef MEM_ARB_PERF_EN
      .stall_cnt(stall_cnt),
`endif
      .nostall  (nostall)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   logic [31:0] mem_model [logic [31:0]];

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return {a[15:0], ~a[15:0]};
   endfunction

   int          cyc;
   int          due = -1;
   logic [31:0] raddr;
   logic [31:0] if_exp[$];
   logic [31:0] dm_exp[$];
   logic [31:0] dm_hold;
   int          n_fetch_en = 0;

   logic        s_mem_en, s_mem_we, s_if_ready, s_dm_ready, s_nostall;
   logic [31:0] s_mem_addr, s_mem_wdata;

   // Observes the current cycle at the falling edge, then moves to just after the next rising edge.
   task automatic step();
      @(negedge clk);
      mem_rdata   = (cyc == due) ? mem_read(raddr) : 32'hBAD0_BAD0;
      s_mem_en    = mem_en;
      s_mem_we    = mem_we;
      s_mem_addr  = mem_addr;
      s_mem_wdata = mem_wdata;
      s_if_ready  = if_ready;
      s_dm_ready  = dm_ready;
      s_nostall   = nostall;
      if (mem_en) begin
         if (!mem_we) n_fetch_en++;
         due   = cyc + int'(MemLat);
         raddr = mem_addr;
         if (mem_we) mem_model[mem_addr] = mem_wdata;
      end
      if (if_ready) begin
         if (if_exp.size() == 0) check("if_ready_spurious", 32'(if_ready), 32'd0);
         else check("if_rdata", if_rdata, if_exp.pop_front());
      end
      if (dm_ready) begin
         if (dm_exp.size() == 0) check("dm_ready_spurious", 32'(dm_ready), 32'd0);
         else check("dm_rdata", dm_rdata, dm_exp.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_ready(input logic is_dm);
      int   n;
      logic got;
      n   = 0;
      got = 1'b0;
      while (!got && n < 30) begin
         step();
         n++;
         got = is_dm ? s_dm_ready : s_if_ready;
      end
      check(is_dm ? "dm_ready_seen" : "if_ready_seen", 32'(got), 32'd1);
      if (got) check("nostall_at_ready", 32'(s_nostall), 32'd1);
   endtask

   task automatic do_if(input logic [31:0] a);
      if_req  = 1'b1;
      if_addr = a;
      if_exp.push_back(mem_read(a));
      wait_ready(1'b0);
      if_req = 1'b0;
   endtask

   task automatic do_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
      dm_req   = 1'b1;
      dm_we    = we;
      dm_addr  = a;
      dm_wdata = d;
      if (!we) dm_hold = mem_read(a);
      dm_exp.push_back(dm_hold);
      wait_ready(1'b1);
      dm_req = 1'b0;
   endtask

   initial begin
      int          nf;
      logic [31:0] a;
      rst       = 1'b1;
      if_req    = 1'b0;
      if_addr   = '0;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      dm_addr   = '0;
      dm_wdata  = '0;
      mem_rdata = 32'hBAD0_BAD0;
      dm_hold   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_if_ready", 32'(if_ready), 32'd0);
      check("rst_dm_ready", 32'(dm_ready), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_dm_rdata", dm_rdata, 32'd0);
      check("rst_nostall", 32'(nostall), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;

      // Single fetch from cycle 0.
      mem_model[32'h3000] = 32'h2001_0005;
      if_req  = 1'b1;
      if_addr = 32'h3000;
      if_exp.push_back(mem_read(32'h3000));
      for (int k = 0; k < 5; k++) begin
         step();
         check("s1_mem_en", 32'(s_mem_en), 32'(k == 1));
         check("s1_nostall", 32'(s_nostall), 32'(k == 4));
         check("s1_if_ready", 32'(s_if_ready), 32'(k == 4));
         if (k == 1) begin
            check("s1_mem_addr", s_mem_addr, 32'h3000);
            check("s1_mem_we", 32'(s_mem_we), 32'd0);
         end
      end
      if_req = 1'b0;
`ifdef MEM_ARB_PERF_EN
      check("s1_stall_cnt", stall_cnt, 32'd4);
`endif
      step();
      step();

      // Simultaneous store and fetch: DM first, fetch exactly once.
      mem_model[32'h3004] = 32'h00A0_0013;
      dm_req   = 1'b1;
      dm_we    = 1'b1;
      dm_addr  = 32'h10;
      dm_wdata = 32'hDEAD_BEEF;
      if_req   = 1'b1;
      if_addr  = 32'h3004;
      dm_exp.push_back(dm_hold);
      if_exp.push_back(mem_read(32'h3004));
      nf = n_fetch_en;
      for (int k = 0; k < 10; k++) begin
         step();
         check("s2_mem_en", 32'(s_mem_en), 32'(k == 1 || k == 6));
         check("s2_dm_ready", 32'(s_dm_ready), 32'(k == 4));
         check("s2_if_ready", 32'(s_if_ready), 32'(k == 9));
         check("s2_nostall", 32'(s_nostall), 32'(k == 9));
         if (k == 1) begin
            check("s2_st_we", 32'(s_mem_we), 32'd1);
            check("s2_st_addr", s_mem_addr, 32'h10);
            check("s2_st_wdata", s_mem_wdata, 32'hDEAD_BEEF);
         end
         if (k == 6) begin
            check("s2_if_we", 32'(s_mem_we), 32'd0);
            check("s2_if_addr", s_mem_addr, 32'h3004);
         end
      end
      dm_req = 1'b0;
      if_req = 1'b0;
      check("s2_if_done_clr", 32'(dut.if_done_q), 32'd0);
      check("s2_dm_done_clr", 32'(dut.dm_done_q), 32'd0);
      repeat (3) step();
      check("s2_fetch_once", 32'(n_fetch_en - nf), 32'd1);

      // Load, then a store that must leave dm_rdata alone, then read-back paths.
      mem_model[32'h20] = 32'h1234_5678;
      do_dm(1'b0, 32'h20, 32'h0);
      do_dm(1'b1, 32'h24, 32'hCAFE_F00D);
      check("s3_dm_rdata_hold", dm_rdata, 32'h1234_5678);
      do_dm(1'b0, 32'h10, 32'h0);
      do_if(32'h24);

      // Request dropped while granted still completes.
      dm_req   = 1'b1;
      dm_we    = 1'b0;
      dm_addr  = 32'h20;
      dm_hold  = mem_read(32'h20);
      dm_exp.push_back(dm_hold);
      step();
      dm_req = 1'b0;
      wait_ready(1'b1);

      // Reset in the cycle after mem_en aborts the fetch; the held request is re-granted.
      if_req  = 1'b1;
      if_addr = 32'h3008;
      if_exp.push_back(mem_read(32'h3008));
      for (int k = 0; k < 8; k++) begin
         if (k == 2) begin
            rst     = 1'b1;
            dm_hold = '0;
         end
         if (k == 3) rst = 1'b0;
         step();
         check("s4_mem_en", 32'(s_mem_en), 32'(k == 1 || k == 4));
         check("s4_if_ready", 32'(s_if_ready), 32'(k == 7));
         if (k == 4) check("s4_mem_addr", s_mem_addr, 32'h3008);
         if (k == 7) check("s4_nostall", 32'(s_nostall), 32'd1);
      end
      if_req = 1'b0;
      step();

      // Mixed random traffic.
      for (int i = 0; i < 6; i++) begin
         a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         if (i % 2 == 1) do_if(a);
         else do_dm(1'($urandom_range(0, 1)), a, $urandom());
      end
      repeat (2) step();

      check("if_queue_empty", 32'(if_exp.size()), 32'd0);
      check("dm_queue_empty", 32'(dm_exp.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
